// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: FSM states and
// parity mode encodings.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit. A synchronous clear restarts the period at a pop.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic bit_end
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign bit_end = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || !en || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter fed from a first-word-fall-through byte FIFO; pops the head
// byte at frame start and sends start, data (LSB first), optional parity, stop.
module uart_tx_fifo_drain
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int DATA_WIDTH = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tx_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  parity_q, parity_d;
   logic                  tx_q, tx_d;
   logic                  bit_end;
   logic                  last_stop;
   logic                  pop;

   assign last_stop = (state_q == ST_STOP) && bit_end && (bit_cnt_q == LAST_STOP);
   // Gated by rst_n so the FIFO is never popped while reset is held.
   assign pop = rst_n && tx_en && !fifo_empty && ((state_q == ST_IDLE) || last_stop);

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (pop),
      .en     (state_q != ST_IDLE),
      .bit_end(bit_end)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         parity_q  <= parity_d;
         tx_q      <= tx_d;
      end
   end

   // NOTE: every comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (pop) state_d = ST_START;
         ST_START:  if (bit_end) state_d = ST_DATA;
         ST_DATA: begin
            if (bit_end && (bit_cnt_q == LAST_DATA)) begin
               state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: if (bit_end) state_d = ST_STOP;
         ST_STOP:   if (last_stop) state_d = pop ? ST_START : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
      if (pop) begin
         shift_d   = fifo_rd_data;
         parity_d  = (^fifo_rd_data) ^ (PARITY == PAR_ODD);
         bit_cnt_d = '0;
      end else if (bit_end) begin
         case (state_q)
            ST_DATA: begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = (bit_cnt_q == LAST_DATA) ? '0 : bit_cnt_q + 1'b1;
            end
            ST_STOP: bit_cnt_d = (bit_cnt_q == LAST_STOP) ? '0 : bit_cnt_q + 1'b1;
            default: ;
         endcase
      end
   end

   // tx is computed from the next state so the line flop changes on the bit boundary itself.
   always_comb begin
      fifo_rd_en = pop;
      busy       = (state_q != ST_IDLE);
      frame_done = last_stop;
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = parity_d;
         default:   tx_d = 1'b1;
      endcase
   end

   assign tx = tx_q;

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- Byte-serial UART transmitter that sits directly downstream of the multi-input shift-register byte FIFO.
- Pops one byte at a time through the FIFO's first-word-fall-through read interface and serialises it onto a single TX line: start bit, data LSB first, optional parity, then stop bit(s).
- Sustains back-to-back frames with no idle gap while the FIFO holds data.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division, must be >= 2).
- DATA_WIDTH, 8, bits per character. Equals the FIFO byte width.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- tx_en, input, 1, level enable; new frames start only while high.
- fifo_rd_data, input, DATA_WIDTH, FIFO head byte; valid whenever fifo_empty is 0.
- fifo_empty, input, 1, FIFO empty flag.
- fifo_rd_en, output, 1, pop strobe to the FIFO (combinational).
- tx, output, 1, serial line; idles high.
- busy, output, 1, high while a frame is on the line.
- frame_done, output, 1, one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - tx = 1, busy = 0, frame_done = 0, fifo_rd_en = 0.
  - State = IDLE; baud counter, bit counter and shift register cleared.
  - Any partially sent frame is abandoned. The byte already popped is lost, and the FIFO is not re-read.
- States: IDLE, START, DATA, PARITY, STOP.
- Baud counter counts 0..CLKS_PER_BIT-1. A bit ends on the cycle the counter reaches CLKS_PER_BIT-1 ("bit_end").
- Pop condition: pop = tx_en && !fifo_empty && (state == IDLE || (state == STOP && bit_end && last stop bit)).
  - fifo_rd_en = pop, purely combinational.
  - On the same clock edge, fifo_rd_data is latched into the shift register, parity is computed from it, and the state goes to START with the counter at 0.
  - Never assert fifo_rd_en while fifo_empty = 1. It is high for exactly one cycle per frame.
- START: tx = 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: tx = shift[0], LSB first. Shift right on each bit_end. After DATA_WIDTH bits, go to PARITY if PARITY != 0, otherwise STOP.
- PARITY: tx = XOR of the data bits for even, its inverse for odd. Lasts one bit period, then STOP.
- STOP: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles.
  - frame_done = 1 on the final cycle.
  - Next state is START if pop, else IDLE.
- busy = (state != IDLE).
- tx is registered: it changes only on bit boundaries and has no glitches. The first start-bit cycle is the cycle after the pop.
- Frame length: (1 + DATA_WIDTH + (PARITY != 0) + STOP_BITS) × CLKS_PER_BIT cycles. Back-to-back frames have zero idle cycles between them.
- tx_en low mid-frame: the current frame completes and no new pop occurs. When tx_en returns high in IDLE, the pop is asserted that same cycle.
- FIFO write activity has no effect on the frame in flight, because the data is latched at the pop.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - parity mode constants PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2.
- One natural sub-module: uart_baud_tick. It holds the CLKS_PER_BIT counter with a synchronous clear (driven by the pop) and outputs bit_end.
- The FSM, bit counter and shift register stay in the top level.

Test Plan:
All scenarios use CLK_FREQ = 1600 and BAUD_RATE = 100, giving CLKS_PER_BIT = 16.
1. Single frame, PARITY = 0, STOP_BITS = 1, FIFO holds 0x55, tx_en = 1:
   - fifo_rd_en pulses for one cycle.
   - Over 160 cycles, tx shows in 16-cycle bits: 0,1,0,1,0,1,0,1,0,1.
   - frame_done pulses at cycle 160; busy then falls and fifo_rd_en stays 0.
2. Back-to-back, FIFO preloaded via a 3-byte write of 0xA1, 0xB2, 0xC3:
   - Three frames in 480 contiguous cycles; tx never high for more than the stop bit between frames.
   - Received bytes in order A1, B2, C3; exactly 3 pops.
3. Parity, PARITY = 1 with byte 0x07, then PARITY = 2 with byte 0x07:
   - Parity bit is 1 for even and 0 for odd.
   - Frame length is 176 cycles in both cases.
4. STOP_BITS = 2, byte 0xFF:
   - tx is high for 32 cycles after the data bits; frame length is 176 cycles.
   - frame_done is asserted on cycle 176 only.
5. tx_en dropped at cycle 40 of a frame, with 2 bytes queued:
   - The current frame completes and no further pop occurs.
   - Re-asserting tx_en pops on that same cycle.
6. rst_n asserted at cycle 70 of a frame:
   - tx = 1, busy = 0 and fifo_rd_en = 0 immediately, without waiting for a clock edge.
   - After release, the next frame carries the next FIFO byte.
